vu_zflag_stage: RTL

//  Consumes per-lane zero-detect results of the VU result bus; registers them

---
 rtl/vu_pkg.sv | 10 +
 rtl/vu_lane_zero.sv | 11 +
 rtl/vu_zflag_stage.sv | 65 ++++++
 3 files changed

// File: rtl/vu_pkg.sv
// Shared vector-unit definitions: lane geometry and the per-lane mask type
// used by the zero-flag, select and merge blocks.
package vu_pkg;

   localparam int VU_LANES  = 8;
   localparam int VU_LANE_W = 16;

   typedef logic [VU_LANES-1:0] lane_mask_t;

endpackage : vu_pkg

// File: rtl/vu_lane_zero.sv
// Single-lane zero detect: a WIDTH-bit NOR of the lane result.
module vu_lane_zero #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] data,
   output logic             zero
);

   assign zero = ~|data;

endmodule : vu_lane_zero

// File: rtl/vu_zflag_stage.sv
// EX->WB registration of per-lane zero results and the VU zero-flag register,
// with a WB bypass so a flag-writing instruction is visible one cycle early.
module vu_zflag_stage
   import vu_pkg::*;
#(
   parameter int LANES = VU_LANES,
   parameter int WIDTH = VU_LANE_W
) (
   input  logic                   clk,
   input  logic                   reset_l,
   input  logic                   su_stall,
   input  logic                   ex_valid,
   input  logic                   ex_kill,
   input  logic                   ex_zf_we,
   input  logic [LANES-1:0]       ex_elem_mask,
   input  logic [LANES*WIDTH-1:0] ex_data,
   input  logic                   su_zf_we,
   input  logic [LANES-1:0]       su_zf_wdata,
   output logic                   wb_valid,
   output logic [LANES-1:0]       zf_flags,
   output logic                   zf_any,
   output logic                   zf_all
);

   logic [LANES-1:0] lane_z;
   logic [LANES-1:0] wb_mask;
   logic [LANES-1:0] wb_zero;
   logic [LANES-1:0] flag_q;
   logic [LANES-1:0] wb_merge;

   for (genvar n = 0; n < LANES; n++) begin : g_lane
      vu_lane_zero #(.WIDTH(WIDTH)) u_zero (
         .data (ex_data[n*WIDTH +: WIDTH]),
         .zero (lane_z[n])
      );
   end

   // Only the selected lanes of the WB instruction replace the stored flags.
   assign wb_merge = (flag_q & ~wb_mask) | (wb_zero & wb_mask);

   // A stall freezes everything, including the kill: EX re-presents it later.
   // An SU write in the same cycle as a WB update wins and the WB update drops.
   always_ff @(posedge clk) begin
      if (!reset_l) begin
         wb_valid <= 1'b0;
         wb_mask  <= '0;
         wb_zero  <= '0;
         flag_q   <= '0;
      end else if (!su_stall) begin
         wb_valid <= ex_valid & ex_zf_we & ~ex_kill;
         wb_mask  <= ex_elem_mask;
         wb_zero  <= lane_z;
         if (su_zf_we) begin
            flag_q <= su_zf_wdata;
         end else if (wb_valid) begin
            flag_q <= wb_merge;
         end
      end
   end

   assign zf_flags = wb_valid ? wb_merge : flag_q;
   assign zf_any   = |zf_flags;
   assign zf_all   = &zf_flags;

endmodule : vu_zflag_stage
